// File: rtl/trigger_window_ctrl.sv
// trigger_window_ctrl
//   Gates data capture for a TDS logger around an asynchronous trigger.
//   A synchronized rising edge of trig_in (while enable_trigger=1) opens a
//   capture window of window_width cycles, then raises log_req until the
//   logger acknowledges, then enforces deadtime idle cycles before re-arming.
//   With enable_trigger=0 the block free-runs: capture_en stays high and
//   trigger edges are ignored.
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   trig_in          : asynchronous trigger level
//   enable_trigger   : 1 = gated capture, 0 = free-run capture
//   window_width     : capture window length in cycles (0 treated as 1)
//   deadtime         : idle cycles after each logged event
//   log_ack          : logger acknowledge, honoured only while flushing
//   clear_cnt        : synchronous clear of both counters
//   capture_en       : registered capture gate
//   log_req          : registered event-complete request
//   busy             : registered, high whenever the FSM is not idle
//   trig_count       : accepted triggers, saturating
//   missed_count     : triggers seen while busy, saturating
module trigger_window_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_in,
  input  logic             enable_trigger,
  input  logic [9:0]       window_width,
  input  logic [7:0]       deadtime,
  input  logic             log_ack,
  input  logic             clear_cnt,
  output logic             capture_en,
  output logic             log_req,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] missed_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    FLUSH  = 2'd2,
    DEAD   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             trig_edge;
  logic [9:0]       win_cnt_q, win_cnt_d;
  logic [7:0]       dead_cnt_q, dead_cnt_d;
  logic [CNT_W-1:0] trig_count_q, trig_count_d;
  logic [CNT_W-1:0] missed_count_q, missed_count_d;
  logic             capture_en_q, capture_en_d;
  logic             log_req_q, log_req_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             miss;

  // State register (also holds synchronizer, down-counters and outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      win_cnt_q      <= '0;
      dead_cnt_q     <= '0;
      trig_count_q   <= '0;
      missed_count_q <= '0;
      capture_en_q   <= 1'b0;
      log_req_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      win_cnt_q      <= win_cnt_d;
      dead_cnt_q     <= dead_cnt_d;
      trig_count_q   <= trig_count_d;
      missed_count_q <= missed_count_d;
      capture_en_q   <= capture_en_d;
      log_req_q      <= log_req_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    s0_d       = trig_in;
    s1_d       = s0_q;
    s2_d       = s1_q;
    trig_edge  = s1_q & ~s2_q;
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    dead_cnt_d = dead_cnt_q;

    if (!enable_trigger) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trig_edge) begin
            state_d   = WINDOW;
            win_cnt_d = (window_width == 10'd0) ? 10'd1 : window_width;
          end
        end
        WINDOW: begin
          if (win_cnt_q <= 10'd1) begin
            state_d = FLUSH;
          end else begin
            win_cnt_d = win_cnt_q - 10'd1;
          end
        end
        FLUSH: begin
          if (log_ack) begin
            if (deadtime != 8'd0) begin
              state_d    = DEAD;
              dead_cnt_d = deadtime;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DEAD: begin
          if (dead_cnt_q <= 8'd1) begin
            state_d = IDLE;
          end else begin
            dead_cnt_d = dead_cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Counters: the edge is classified by the state it arrives in
    accept = enable_trigger & trig_edge & (state_q == IDLE);
    miss   = enable_trigger & trig_edge & (state_q != IDLE);

    if (clear_cnt) begin
      trig_count_d = '0;
    end else if (accept && (trig_count_q != '1)) begin
      trig_count_d = trig_count_q + CNT_ONE;
    end else begin
      trig_count_d = trig_count_q;
    end

    if (clear_cnt) begin
      missed_count_d = '0;
    end else if (miss && (missed_count_q != '1)) begin
      missed_count_d = missed_count_q + CNT_ONE;
    end else begin
      missed_count_d = missed_count_q;
    end
  end

  // Output logic: decoded from the next state so the outputs are registered
  // yet line up with the state they describe.
  always_comb begin
    capture_en_d = ~enable_trigger | (state_d == WINDOW);
    log_req_d    = enable_trigger & (state_d == FLUSH);
    busy_d       = (state_d != IDLE);
  end

  assign capture_en   = capture_en_q;
  assign log_req      = log_req_q;
  assign busy         = busy_q;
  assign trig_count   = trig_count_q;
  assign missed_count = missed_count_q;

endmodule

// File: tb/tb_trigger_window_ctrl.sv
// Self-checking bench for trigger_window_ctrl (4-bit counters so that
// saturation is reachable quickly).
module tb_trigger_window_ctrl;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic          clk;
  logic          rst_n;
  logic          trig_in;
  logic          enable_trigger;
  logic [9:0]    window_width;
  logic [7:0]    deadtime;
  logic          log_ack;
  logic          clear_cnt;
  logic          capture_en;
  logic          log_req;
  logic          busy;
  logic [CW-1:0] trig_count;
  logic [CW-1:0] missed_count;

  int unsigned errors;
  int unsigned checks;

  trigger_window_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trig_in        (trig_in),
    .enable_trigger (enable_trigger),
    .window_width   (window_width),
    .deadtime       (deadtime),
    .log_ack        (log_ack),
    .clear_cnt      (clear_cnt),
    .capture_en     (capture_en),
    .log_req        (log_req),
    .busy           (busy),
    .trig_count     (trig_count),
    .missed_count   (missed_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: event phases tracked by absolute cycle deadlines.
  // mode 0 idle, 1 capture window, 2 awaiting ack, 3 deadtime.
  int cyc;
  int m_mode;
  int m_win_end;
  int m_dead_end;
  int m_trig;
  int m_miss;
  bit h1, h2, h3;          // trig_in as sampled 1, 2 and 3 edges ago
  bit e_cap, e_req, e_busy;

  function automatic void mdl_reset();
    m_mode = 0; m_win_end = 0; m_dead_end = 0;
    m_trig = 0; m_miss = 0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    e_cap = 1'b0; e_req = 1'b0; e_busy = 1'b0;
  endfunction

  // Advance one clock edge: DUT and model together, leave time at edge+1.
  task automatic tick();
    bit edge_seen;
    int pre;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mdl_reset();
    end else begin
      edge_seen = h2 & ~h3;   // rise first sampled two edges ago
      h3 = h2; h2 = h1; h1 = trig_in;
      pre = m_mode;
      if (!enable_trigger) begin
        m_mode = 0;
      end else begin
        case (pre)
          0: if (edge_seen) begin
               m_mode    = 1;
               m_win_end = cyc + ((window_width == 0) ? 1 : int'(window_width));
             end
          1: if (cyc == m_win_end) m_mode = 2;
          2: if (log_ack) begin
               if (deadtime > 0) begin
                 m_mode     = 3;
                 m_dead_end = cyc + int'(deadtime);
               end else begin
                 m_mode = 0;
               end
             end
          default: if (cyc == m_dead_end) m_mode = 0;
        endcase
      end
      if (clear_cnt) begin
        m_trig = 0;
        m_miss = 0;
      end else if (enable_trigger && edge_seen) begin
        if (pre == 0) begin
          if (m_trig < CMAX) m_trig++;
        end else begin
          if (m_miss < CMAX) m_miss++;
        end
      end
      e_cap  = !enable_trigger || (m_mode == 1);
      e_req  = enable_trigger && (m_mode == 2);
      e_busy = (m_mode != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig_in = 1'b0; enable_trigger = 1'b1;
    window_width = 10'd5; deadtime = 8'd3; log_ack = 1'b0; clear_cnt = 1'b0;
    mdl_reset();
    repeat (3) tick();
    checks++; if (capture_en !== 1'b0) begin errors++; $display("FAIL reset_cap got=%0b exp=0", capture_en); end
    checks++; if (log_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", log_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (trig_count !== 4'd0) begin errors++; $display("FAIL reset_trig got=%0d exp=0", trig_count); end
    checks++; if (missed_count !== 4'd0) begin errors++; $display("FAIL reset_miss got=%0d exp=0", missed_count); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (capture_en !== 1'b0) begin errors++; $display("FAIL idle_cap got=%0b exp=0", capture_en); end
  endtask

  // width=5, deadtime=3, ack at N+10; width/deadtime changed mid-event.
  task automatic test_basic();
    window_width = 10'd5; deadtime = 8'd3;
    trig_in = 1'b1;
    tick();                              // edge N
    for (int j = 1; j <= 14; j++) begin
      trig_in = (j < 3);
      log_ack = (j == 10);
      if (j == 3)  window_width = 10'd9;
      if (j == 11) deadtime = 8'd0;
      tick();                            // edge N+j
      checks++;
      if (capture_en !== ((j >= 2) && (j < 7))) begin
        errors++; $display("FAIL basic_cap j=%0d got=%0b exp=%0b", j, capture_en, (j >= 2) && (j < 7));
      end
      checks++;
      if (log_req !== ((j >= 7) && (j < 10))) begin
        errors++; $display("FAIL basic_req j=%0d got=%0b exp=%0b", j, log_req, (j >= 7) && (j < 10));
      end
      checks++;
      if (busy !== ((j >= 2) && (j < 13))) begin
        errors++; $display("FAIL basic_busy j=%0d got=%0b exp=%0b", j, busy, (j >= 2) && (j < 13));
      end
    end
    log_ack = 1'b0;
    checks++; if (trig_count !== 4'd1) begin errors++; $display("FAIL basic_trig got=%0d exp=1", trig_count); end
    checks++; if (missed_count !== 4'd0) begin errors++; $display("FAIL basic_miss got=%0d exp=0", missed_count); end
  endtask

  task automatic test_zero_width();
    window_width = 10'd0; deadtime = 8'd0;
    trig_in = 1'b1;
    tick();
    for (int j = 1; j <= 8; j++) begin
      trig_in = (j < 2);
      log_ack = (j == 5);
      tick();
      checks++;
      if (capture_en !== (j == 2)) begin
        errors++; $display("FAIL zero_cap j=%0d got=%0b exp=%0b", j, capture_en, j == 2);
      end
      checks++;
      if (log_req !== ((j >= 3) && (j < 5))) begin
        errors++; $display("FAIL zero_req j=%0d got=%0b exp=%0b", j, log_req, (j >= 3) && (j < 5));
      end
      checks++;
      if (busy !== ((j >= 2) && (j < 5))) begin
        errors++; $display("FAIL zero_busy j=%0d got=%0b exp=%0b", j, busy, (j >= 2) && (j < 5));
      end
    end
    log_ack = 1'b0;
    checks++; if (trig_count !== 4'd2) begin errors++; $display("FAIL zero_trig got=%0d exp=2", trig_count); end
  endtask

  task automatic test_missed();
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    checks++; if (trig_count !== 4'd0) begin errors++; $display("FAIL clr_trig got=%0d exp=0", trig_count); end
    window_width = 10'd8; deadtime = 8'd6;
    trig_in = 1'b1;
    tick();
    for (int j = 1; j <= 22; j++) begin
      trig_in = (j == 4) || (j == 7) || (j == 13);
      log_ack = (j == 12);
      tick();
    end
    log_ack = 1'b0;
    checks++; if (trig_count !== 4'd1) begin errors++; $display("FAIL missed_trig got=%0d exp=1", trig_count); end
    checks++; if (missed_count !== 4'd3) begin errors++; $display("FAIL missed_miss got=%0d exp=3", missed_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL missed_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_saturate();
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    window_width = 10'd1023; deadtime = 8'd0;
    trig_in = 1'b1; tick(); trig_in = 1'b0; tick(); tick();
    for (int i = 0; i < 15; i++) begin
      trig_in = 1'b1; tick(); trig_in = 1'b0; tick();
    end
    repeat (3) tick();
    checks++; if (missed_count !== 4'd15) begin errors++; $display("FAIL sat_fill got=%0d exp=15", missed_count); end
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    repeat (3) tick();
    checks++; if (missed_count !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", missed_count); end
    checks++; if (trig_count !== 4'd1) begin errors++; $display("FAIL sat_trig got=%0d exp=1", trig_count); end
    // Miss increment lands two edges after trig_in is sampled; clear there.
    trig_in = 1'b1; tick(); trig_in = 1'b0; tick();
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    checks++; if (missed_count !== 4'd0) begin errors++; $display("FAIL sat_clear got=%0d exp=0", missed_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy got=%0b exp=1", busy); end
    enable_trigger = 1'b0; tick(); enable_trigger = 1'b1; tick();
  endtask

  task automatic test_disable();
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    window_width = 10'd2; deadtime = 8'd0;
    trig_in = 1'b1; tick();
    trig_in = 1'b0;
    repeat (4) tick();
    checks++; if (log_req !== 1'b1) begin errors++; $display("FAIL dis_flush got=%0b exp=1", log_req); end
    enable_trigger = 1'b0;
    tick();
    checks++; if (log_req !== 1'b0) begin errors++; $display("FAIL dis_req got=%0b exp=0", log_req); end
    checks++; if (capture_en !== 1'b1) begin errors++; $display("FAIL dis_cap got=%0b exp=1", capture_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy got=%0b exp=0", busy); end
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    repeat (5) tick();
    checks++; if (trig_count !== 4'd1) begin errors++; $display("FAIL dis_trig got=%0d exp=1", trig_count); end
    checks++; if (missed_count !== 4'd0) begin errors++; $display("FAIL dis_miss got=%0d exp=0", missed_count); end
    checks++; if (capture_en !== 1'b1) begin errors++; $display("FAIL dis_cap_hold got=%0b exp=1", capture_en); end
    enable_trigger = 1'b1;
    tick();
    checks++; if (capture_en !== 1'b0) begin errors++; $display("FAIL reen_cap got=%0b exp=0", capture_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reen_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    window_width = 10'd6; deadtime = 8'd2;
    trig_in = 1'b1; tick();
    trig_in = 1'b0;
    repeat (3) tick();
    checks++; if (capture_en !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%0b exp=1", capture_en); end
    #1 rst_n = 1'b0;
    mdl_reset();
    #1;
    checks++; if (capture_en !== 1'b0) begin errors++; $display("FAIL rmid_cap got=%0b exp=0", capture_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    checks++; if (trig_count !== 4'd0) begin errors++; $display("FAIL rmid_trig got=%0d exp=0", trig_count); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (log_req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%0b exp=0", log_req); end
    trig_in = 1'b1; tick();
    for (int j = 1; j <= 12; j++) begin
      trig_in = 1'b0;
      log_ack = (j == 9);
      tick();
      checks++;
      if (capture_en !== ((j >= 2) && (j < 8))) begin
        errors++; $display("FAIL rpost_cap j=%0d got=%0b exp=%0b", j, capture_en, (j >= 2) && (j < 8));
      end
      checks++;
      if (log_req !== (j == 8)) begin
        errors++; $display("FAIL rpost_req j=%0d got=%0b exp=%0b", j, log_req, j == 8);
      end
      checks++;
      if (busy !== ((j >= 2) && (j < 11))) begin
        errors++; $display("FAIL rpost_busy j=%0d got=%0b exp=%0b", j, busy, (j >= 2) && (j < 11));
      end
    end
    log_ack = 1'b0;
    checks++; if (trig_count !== 4'd1) begin errors++; $display("FAIL rpost_trig got=%0d exp=1", trig_count); end
  endtask

  task automatic test_random();
    rst_n = 1'b0; trig_in = 1'b0; log_ack = 1'b0; clear_cnt = 1'b0;
    mdl_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      enable_trigger = ($urandom_range(0, 99) >= 3);
      trig_in        = ($urandom_range(0, 3) == 0);
      log_ack        = ($urandom_range(0, 3) == 0);
      clear_cnt      = ($urandom_range(0, 199) == 0);
      window_width   = 10'($urandom_range(0, 6));
      deadtime       = 8'($urandom_range(0, 4));
      tick();
      checks++;
      if (capture_en !== e_cap) begin
        errors++; $display("FAIL rnd_cap i=%0d got=%0b exp=%0b", i, capture_en, e_cap);
      end
      checks++;
      if (log_req !== e_req) begin
        errors++; $display("FAIL rnd_req i=%0d got=%0b exp=%0b", i, log_req, e_req);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL rnd_busy i=%0d got=%0b exp=%0b", i, busy, e_busy);
      end
      checks++;
      if (int'(trig_count) != m_trig) begin
        errors++; $display("FAIL rnd_trig i=%0d got=%0d exp=%0d", i, trig_count, m_trig);
      end
      checks++;
      if (int'(missed_count) != m_miss) begin
        errors++; $display("FAIL rnd_miss i=%0d got=%0d exp=%0d", i, missed_count, m_miss);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    test_reset();
    test_basic();
    test_zero_width();
    test_missed();
    test_saturate();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
